// File: rtl/mem_request_sequencer.sv
// Turns key/switch I/O requests into Avalon-MM single write, single read or
// zero-fill sweep transactions toward the SDRAM controller.
module mem_request_sequencer #(
    parameter int ADDR_W      = 25,
    parameter int DATA_W      = 16,
    parameter int CLEAR_WORDS = 33554432,
    parameter int RD_TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode_in,
    input  logic              io_done,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              mem_done,
    output logic              done_pulse,
    output logic [DATA_W-1:0] read_data,
    output logic              rd_err,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic              avm_read,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid
);

    localparam int TO_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT + 1) : 1;
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(CLEAR_WORDS - 1);
    localparam logic [TO_W-1:0]   TO_LIMIT  = TO_W'(RD_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ_CMD,
        READ_WAIT,
        CLEAR,
        FINISH
    } state_t;

    state_t            state;
    logic              ioDoneQ;
    logic [ADDR_W-1:0] sweepCount;
    logic [TO_W-1:0]   waitCount;
    logic [TO_W-1:0]   waitNext;
    logic              start;

    assign start    = io_done & ~ioDoneQ;
    assign waitNext = waitCount + 1'b1;

    // NOTE: every register here, read_data included, is software-visible, so the
    // synchronous reset covers all of them; state updates use <= so each edge
    // sees only the previous cycle's values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ioDoneQ       <= 1'b0;
            sweepCount    <= '0;
            waitCount     <= '0;
            mem_done      <= 1'b1;
            done_pulse    <= 1'b0;
            read_data     <= '0;
            rd_err        <= 1'b0;
            avm_address   <= '0;
            avm_write     <= 1'b0;
            avm_read      <= 1'b0;
            avm_writedata <= '0;
        end else begin
            ioDoneQ    <= io_done;
            done_pulse <= 1'b0;

            case (state)
                IDLE: begin
                    // Request fields go straight into the command registers.
                    if (start) begin
                        case (mode_in)
                            2'b10: begin
                                state         <= WRITE;
                                mem_done      <= 1'b0;
                                avm_write     <= 1'b1;
                                avm_address   <= io_addr;
                                avm_writedata <= io_wdata;
                            end
                            2'b01: begin
                                state       <= READ_CMD;
                                mem_done    <= 1'b0;
                                avm_read    <= 1'b1;
                                avm_address <= io_addr;
                            end
                            2'b00: begin
                                state         <= CLEAR;
                                mem_done      <= 1'b0;
                                avm_write     <= 1'b1;
                                avm_address   <= '0;
                                avm_writedata <= '0;
                                sweepCount    <= '0;
                            end
                            default: ;
                        endcase
                    end
                end

                WRITE: begin
                    if (!avm_waitrequest) begin
                        avm_write  <= 1'b0;
                        done_pulse <= 1'b1;
                        state      <= FINISH;
                    end
                end

                READ_CMD: begin
                    if (!avm_waitrequest) begin
                        avm_read  <= 1'b0;
                        waitCount <= '0;
                        state     <= READ_WAIT;
                    end
                end

                READ_WAIT: begin
                    if (avm_readdatavalid) begin
                        read_data  <= avm_readdata;
                        rd_err     <= 1'b0;
                        done_pulse <= 1'b1;
                        state      <= FINISH;
                    end else begin
                        waitCount <= waitNext;
                        if (waitNext == TO_LIMIT) begin
                            rd_err     <= 1'b1;
                            done_pulse <= 1'b1;
                            state      <= FINISH;
                        end
                    end
                end

                CLEAR: begin
                    // Address advances only on acceptance, so stalls never skip a word.
                    if (!avm_waitrequest) begin
                        if (sweepCount == LAST_WORD) begin
                            avm_write  <= 1'b0;
                            sweepCount <= '0;
                            done_pulse <= 1'b1;
                            state      <= FINISH;
                        end else begin
                            sweepCount  <= sweepCount + 1'b1;
                            avm_address <= sweepCount + 1'b1;
                        end
                    end
                end

                FINISH: begin
                    mem_done <= 1'b1;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_request_sequencer.sv
// Bench for mem_request_sequencer: directed vector table, corner-case sequences
// and randomized requests against a transaction-level expectation model.
module tb_mem_request_sequencer;

    localparam int ADDR_W      = 25;
    localparam int DATA_W      = 16;
    localparam int CLEAR_WORDS = 8;
    localparam int RD_TIMEOUT  = 255;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        mode_in;
    logic              io_done;
    logic [ADDR_W-1:0] io_addr;
    logic [DATA_W-1:0] io_wdata;
    logic              mem_done;
    logic              done_pulse;
    logic [DATA_W-1:0] read_data;
    logic              rd_err;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_write;
    logic              avm_read;
    logic [DATA_W-1:0] avm_writedata;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;

    always #5 clk = ~clk;

    mem_request_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLEAR_WORDS(CLEAR_WORDS), .RD_TIMEOUT(RD_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .mode_in(mode_in), .io_done(io_done), .io_addr(io_addr),
        .io_wdata(io_wdata), .mem_done(mem_done), .done_pulse(done_pulse),
        .read_data(read_data), .rd_err(rd_err), .avm_address(avm_address),
        .avm_write(avm_write), .avm_read(avm_read), .avm_writedata(avm_writedata),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } acc_t;

    typedef struct {
        logic [1:0]        mode;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                stall;   // leading stall cycles; -1 = random per cycle
        int                rdvDelay; // cycles after accept; 0 = never
        logic [DATA_W-1:0] rdData;
        int                expLat;  // io_done raise to done_pulse; -1 = unchecked
        int                expWrites;
        int                expAccLat;
        logic [DATA_W-1:0] expReadData;
        logic              expRdErr;
    } vec_t;

    int nChecks = 0;
    int nErrors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus monitor: a command is accepted at the next rising edge when seen here.
    acc_t              wrQ[$];
    int                doneCnt = 0;
    int                rdAccCnt = 0;
    int                wrHigh = 0;
    logic [ADDR_W-1:0] rdAddr = '0;
    logic              prevHold = 1'b0;
    logic [ADDR_W-1:0] prevAddr = '0;
    logic [DATA_W-1:0] prevData = '0;

    always @(negedge clk) begin
        if (!rst) begin
            check("rw_exclusive", avm_read & avm_write, 0);
            if (prevHold) begin
                check("stall_write_held", avm_write, 1);
                check("stall_addr_held", avm_address, prevAddr);
                check("stall_data_held", avm_writedata, prevData);
            end
            if (avm_write) wrHigh <= wrHigh + 1;
            if (avm_write && !avm_waitrequest) wrQ.push_back({avm_address, avm_writedata});
            if (avm_read && !avm_waitrequest) begin
                rdAccCnt <= rdAccCnt + 1;
                rdAddr   <= avm_address;
            end
            if (done_pulse) doneCnt <= doneCnt + 1;
        end
        prevHold <= !rst && avm_write && avm_waitrequest;
        prevAddr <= avm_address;
        prevData <= avm_writedata;
    end

    function automatic vec_t mkVec(logic [1:0] m, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d,
                                   int st, int rdv, logic [DATA_W-1:0] rdd, int eLat,
                                   int eWr, int eAcc, logic [DATA_W-1:0] eRd, logic eErr);
        vec_t v;
        v.mode = m; v.addr = a; v.wdata = d; v.stall = st; v.rdvDelay = rdv; v.rdData = rdd;
        v.expLat = eLat; v.expWrites = eWr; v.expAccLat = eAcc;
        v.expReadData = eRd; v.expRdErr = eErr;
        return v;
    endfunction

    // Issues one request, plays the bus slave, and checks the outcome.
    task automatic runReq(input string tag, input vec_t v, input bit hold);
        int cyc, stallLeft, sinceAcc, bD, bW, bR, bH;
        bit readAcc, done, busyHigh;
        cyc = 0; stallLeft = v.stall; sinceAcc = 0;
        readAcc = 0; done = 0; busyHigh = 0;
        bD = doneCnt; bW = wrQ.size(); bR = rdAccCnt; bH = wrHigh;
        mode_in = v.mode; io_addr = v.addr; io_wdata = v.wdata; io_done = 1'b1;
        tick();
        while (!done && cyc < 700) begin
            if (done_pulse) begin
                done = 1'b1;
            end else begin
                if (mem_done) busyHigh = 1'b1;
                if (readAcc) sinceAcc++;
                avm_readdatavalid = readAcc && v.rdvDelay != 0 && sinceAcc == v.rdvDelay;
                avm_readdata = avm_readdatavalid ? v.rdData : DATA_W'($urandom);
                if (avm_write || avm_read) begin
                    if (v.stall < 0) avm_waitrequest = 1'($urandom_range(0, 1));
                    else if (stallLeft > 0) begin
                        avm_waitrequest = 1'b1;
                        stallLeft--;
                    end else avm_waitrequest = 1'b0;
                    if (avm_read && !avm_waitrequest) readAcc = 1'b1;
                end else begin
                    avm_waitrequest = 1'($urandom_range(0, 1));
                end
                tick();
                cyc++;
            end
        end
        check({tag, "_completed"}, done, 1);
        check({tag, "_memdone_in_finish"}, mem_done, 0);
        avm_readdatavalid = 1'b0;
        avm_waitrequest   = 1'b0;
        if (!hold) io_done = 1'b0;
        tick();
        check({tag, "_memdone_after"}, mem_done, 1);
        check({tag, "_pulse_single_cycle"}, done_pulse, 0);
        check({tag, "_memdone_low_while_busy"}, busyHigh, 0);
        check({tag, "_done_pulses"}, doneCnt - bD, 1);
        check({tag, "_write_accepts"}, wrQ.size() - bW, v.expWrites);
        check({tag, "_read_accepts"}, rdAccCnt - bR, (v.mode == 2'b01) ? 1 : 0);
        if (v.expLat >= 0) check({tag, "_latency"}, cyc + 1, v.expLat);
        if (v.mode == 2'b10) begin
            if (v.stall >= 0) check({tag, "_write_cmd_cycles"}, wrHigh - bH, v.stall + 1);
            if (wrQ.size() > bW) begin
                check({tag, "_write_addr"}, wrQ[bW].addr, v.addr);
                check({tag, "_write_data"}, wrQ[bW].data, v.wdata);
            end
        end
        if (v.mode == 2'b00) begin
            for (int i = 0; i < v.expWrites && bW + i < wrQ.size(); i++) begin
                check($sformatf("%s_clear_addr%0d", tag, i), wrQ[bW + i].addr, i);
                check($sformatf("%s_clear_data%0d", tag, i), wrQ[bW + i].data, 0);
            end
        end
        if (v.mode == 2'b01) begin
            check({tag, "_read_addr"}, rdAddr, v.addr);
            check({tag, "_accept_to_done"}, sinceAcc, v.expAccLat);
        end
        check({tag, "_read_data"}, read_data, v.expReadData);
        check({tag, "_rd_err"}, rd_err, v.expRdErr);
    endtask

    vec_t tbl[7];
    vec_t rv;
    int   bD, bW, bR, r, st, rdv;
    bit   found;
    logic [DATA_W-1:0] lastRd, rdd;
    logic              lastErr;

    initial begin
        rst = 1'b1; mode_in = 2'b11; io_done = 1'b0; io_addr = '0; io_wdata = '0;
        avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;

        //             mode   addr        wdata    st  rdv rdData   lat wr  acc  readData err
        tbl[0] = mkVec(2'b10, 25'h0001234, 16'hBEEF, 0, 0, 16'h0000, 2, 1, -1, 16'h0000, 1'b0);
        tbl[1] = mkVec(2'b10, 25'h1555555, 16'h1234, 3, 0, 16'h0000, 5, 1, -1, 16'h0000, 1'b0);
        tbl[2] = mkVec(2'b01, 25'h1000000, 16'h0000, 0, 3, 16'hA5C3, -1, 0, 3, 16'hA5C3, 1'b0);
        tbl[3] = mkVec(2'b01, 25'h0000042, 16'h0000, 0, 0, 16'h0000, -1, 0, 255, 16'hA5C3, 1'b1);
        tbl[4] = mkVec(2'b01, 25'h0ABCDEF, 16'h0000, 2, 1, 16'h0F0F, -1, 0, 1, 16'h0F0F, 1'b0);
        tbl[5] = mkVec(2'b00, 25'h1FFFFFF, 16'hFFFF, -1, 0, 16'h0000, -1, 8, -1, 16'h0F0F, 1'b0);
        tbl[6] = mkVec(2'b10, 25'h1FFFFFF, 16'hFFFF, 0, 0, 16'h0000, 2, 1, -1, 16'h0F0F, 1'b0);

        repeat (3) tick();
        check("rst_mem_done", mem_done, 1);
        check("rst_done_pulse", done_pulse, 0);
        check("rst_read_data", read_data, 0);
        check("rst_rd_err", rd_err, 0);
        check("rst_avm_read", avm_read, 0);
        check("rst_avm_write", avm_write, 0);
        check("rst_avm_address", avm_address, 0);
        check("rst_avm_writedata", avm_writedata, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) runReq($sformatf("vec%0d", i), tbl[i], 1'b0);

        // Idle mode: no bus activity and mem_done stays high.
        bD = doneCnt; bW = wrQ.size(); bR = rdAccCnt;
        mode_in = 2'b11; io_addr = 25'h0000100; io_done = 1'b1;
        repeat (4) tick();
        check("idle_mem_done", mem_done, 1);
        check("idle_no_write", wrQ.size() - bW, 0);
        check("idle_no_read", rdAccCnt - bR, 0);
        check("idle_no_done", doneCnt - bD, 0);
        io_done = 1'b0;
        tick();

        // Level held through completion must not retrigger.
        runReq("hold", mkVec(2'b10, 25'h0000055, 16'hCAFE, 1, 0, 16'h0, 3, 1, -1, 16'h0F0F, 1'b0), 1'b1);
        bD = doneCnt; bW = wrQ.size();
        repeat (6) tick();
        check("hold_no_retrigger_write", wrQ.size() - bW, 0);
        check("hold_no_retrigger_done", doneCnt - bD, 0);
        check("hold_mem_done", mem_done, 1);
        io_done = 1'b0;
        tick();

        // Fresh edge while a read is waiting for data is dropped.
        bD = doneCnt; bW = wrQ.size(); bR = rdAccCnt;
        mode_in = 2'b01; io_addr = 25'h0000777; io_done = 1'b1; avm_waitrequest = 1'b0;
        tick();
        tick();
        io_done = 1'b0;
        tick();
        io_done = 1'b1; mode_in = 2'b10; io_addr = 25'h0000888; io_wdata = 16'h5555;
        tick();
        check("busy_mem_done_low", mem_done, 0);
        avm_readdatavalid = 1'b1; avm_readdata = 16'h7777;
        tick();
        check("busy_done_pulse", done_pulse, 1);
        avm_readdatavalid = 1'b0;
        repeat (4) tick();
        check("busy_read_data", read_data, 16'h7777);
        check("busy_single_done", doneCnt - bD, 1);
        check("busy_no_write", wrQ.size() - bW, 0);
        check("busy_one_read", rdAccCnt - bR, 1);
        check("busy_mem_done_after", mem_done, 1);
        io_done = 1'b0;
        tick();

        // Reset in the middle of a clear sweep.
        bD = doneCnt; bW = wrQ.size();
        mode_in = 2'b00; io_done = 1'b1; avm_waitrequest = 1'b0;
        tick();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (avm_write && avm_address == 25'd5) found = 1'b1;
            else tick();
        end
        check("clr_reached_addr5", found, 1);
        rst = 1'b1; io_done = 1'b0;
        tick();
        check("clr_rst_write_low", avm_write, 0);
        check("clr_rst_mem_done", mem_done, 1);
        check("clr_rst_no_pulse", done_pulse, 0);
        rst = 1'b0;
        tick();
        check("clr_rst_accepts", wrQ.size() - bW, 5);
        for (int i = 0; i < 5 && bW + i < wrQ.size(); i++)
            check($sformatf("clr_rst_addr%0d", i), wrQ[bW + i].addr, i);
        check("clr_rst_no_done", doneCnt - bD, 0);
        check("clr_rst_read_data", read_data, 0);

        // Reset during a read; the late readdatavalid must be ignored.
        bD = doneCnt;
        mode_in = 2'b01; io_addr = 25'h0000123; io_done = 1'b1;
        tick();
        tick();
        rst = 1'b1; io_done = 1'b0;
        tick();
        rst = 1'b0; avm_readdatavalid = 1'b1; avm_readdata = 16'hDEAD;
        tick();
        avm_readdatavalid = 1'b0;
        tick();
        check("late_rdv_read_data", read_data, 0);
        check("late_rdv_rd_err", rd_err, 0);
        check("late_rdv_no_done", doneCnt - bD, 0);
        check("late_rdv_mem_done", mem_done, 1);

        runReq("clr_restart", mkVec(2'b00, 25'h0, 16'h0, 0, 0, 16'h0, -1, 8, -1, 16'h0, 1'b0), 1'b0);

        // Randomized requests against the transaction-level model.
        lastRd = '0; lastErr = 1'b0;
        for (int n = 0; n < 24; n++) begin
            r   = int'($urandom_range(0, 6));
            st  = int'($urandom_range(0, 3));
            rdv = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 8));
            rdd = DATA_W'($urandom);
            if (r <= 2) begin
                rv = mkVec(2'b10, ADDR_W'($urandom), DATA_W'($urandom), st, 0, rdd,
                           st + 2, 1, -1, lastRd, lastErr);
            end else if (r <= 5) begin
                if (rdv != 0) begin
                    lastRd = rdd;
                    lastErr = 1'b0;
                end else lastErr = 1'b1;
                rv = mkVec(2'b01, ADDR_W'($urandom), 16'h0, st, rdv, rdd, -1, 0,
                           (rdv != 0) ? rdv : RD_TIMEOUT, lastRd, lastErr);
            end else begin
                rv = mkVec(2'b00, ADDR_W'($urandom), DATA_W'($urandom), -1, 0, rdd, -1,
                           CLEAR_WORDS, -1, lastRd, lastErr);
            end
            runReq($sformatf("rnd%0d", n), rv, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", nErrors);
        $fatal(1);
    end

endmodule
